swz_dma_sched: RTL
==================

SWZ_DMA_SCHED -- requirements
Module: swz_dma_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of CRAM requesters sharing one swizzle_cram_to_dram instance.
REQ-002 SHALL have parameter RAM_AWIDTH, default 9, CRAM read address width.
REQ-003 SHALL have parameter MEM_AWIDTH, default 9, memory-controller start address width.
REQ-004 SHALL have parameter LEN_WIDTH, default 10, transfer length width in words.
REQ-005 SHALL have parameter BLOCK_WORDS, default 40, swizzle buffer switch count; legal lengths are multiples of it.
REQ-006 SHALL have parameter DRAIN_CYCLES, default 42, cycles waited after the last word for the swizzle to empty.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 req  in  NUM_REQ  per-requester transfer request, level.
REQ-010 req_dst_addr  in  NUM_REQ*MEM_AWIDTH  per-requester DRAM start address.
REQ-011 req_len  in  NUM_REQ*LEN_WIDTH  per-requester length in words.
REQ-012 gnt  out  NUM_REQ  one-hot grant, held for the whole transfer.
REQ-013 done  out  NUM_REQ  one-cycle completion pulse.
REQ-014 err  out  NUM_REQ  one-cycle rejection pulse for an illegal length.
REQ-015 mc_stall  in  1  memory-controller backpressure; pauses word issue.
REQ-016 ram_rd_en / ram_rd_addr  out  1 / RAM_AWIDTH  read strobe and address to the granted CRAM.
REQ-017 sw_data_valid / sw_data_last / sw_addr_start  out  1 / 1 / MEM_AWIDTH  swizzle sequencing controls.

Function
REQ-018 States SHALL be IDLE, LOAD, DRAIN, DONE.
REQ-019 IDLE with any req SHALL pick a winner, latch its address and length, and assert gnt the next cycle. A legal length enters LOAD.
REQ-020 An illegal length (0, or not a multiple of BLOCK_WORDS) SHALL pulse err for that requester for one cycle, give no grant, stay in IDLE, and advance the arbitration pointer.
REQ-021 In LOAD with mc_stall low, the block SHALL assert ram_rd_en and increment ram_rd_addr from 0 each cycle. With mc_stall high, ram_rd_en SHALL be 0 and the address SHALL hold.
REQ-022 sw_data_valid SHALL equal ram_rd_en delayed by exactly 1 cycle (CRAM read latency).
REQ-023 sw_data_last SHALL be asserted only together with the final word's sw_data_valid.
REQ-024 sw_addr_start SHALL hold the latched address, stable from grant until done.
REQ-025 After the last read issues, LOAD SHALL go to DRAIN. DRAIN SHALL count DRAIN_CYCLES, ignoring mc_stall, then go to DONE.
REQ-026 DONE SHALL pulse done for the granted requester, drop gnt, and return to IDLE. The next grant comes no earlier than the following cycle.
REQ-027 Deasserting req mid-transfer SHALL be ignored; the transfer completes.
REQ-028 Round-robin: after a grant or rejection of index i, search SHALL start at i+1 mod NUM_REQ.

Reset
REQ-029 Reset SHALL force IDLE, arbitration pointer 0, and all outputs 0 on the next edge, including mid-transfer (the transfer is aborted, with no done pulse).

Configuration
REQ-030 With SWZ_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins, pointer unused). Without it, arbitration SHALL be round-robin per REQ-028.

Structure
REQ-031 Package swz_sched_pkg SHALL hold the state enum and the BLOCK_WORDS/DRAIN_CYCLES defaults.
REQ-032 Arbitration SHALL be a sub-module swz_rr_arbiter (req, pointer -> one-hot winner and index).

Verification
REQ-033 Single requester: req[0], len 80, addr 0x010 -> gnt[0] next cycle; 80 ram_rd_en cycles; sw_data_last on word 80; done[0] 42 cycles after the last valid.
REQ-034 Contention: req = 4'b1111, len 40 each -> grants in order 0,1,2,3, each done before the next gnt.
REQ-035 Stall: mc_stall high for 5 cycles at word 20 -> ram_rd_addr holds at 20; sw_data_valid gap exactly 5 cycles; 80 valids total.
REQ-036 Illegal length: req[2] with len 50 -> err[2] pulse, no gnt[2]; then req[3] granted.
REQ-037 Reset mid-LOAD at word 30 -> next cycle all outputs 0, IDLE, no done pulse.
REQ-038 Macro: with SWZ_SCHED_FIXED_PRIO_EN defined and req[0] held continuously -> req[1] is never granted.

Source files
------------

// File: rtl/swz_sched_pkg.sv
// Shared types and default timing constants for the swizzle DMA scheduler.
package swz_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int DEF_BLOCK_WORDS  = 40;
  localparam int DEF_DRAIN_CYCLES = 42;

endpackage

// File: rtl/swz_rr_arbiter.sv
// Rotating-priority arbiter: the lowest requester at or above ptr wins,
// otherwise the search wraps to the lowest requester overall.
module swz_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (PW'(i) >= ptr)) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = PW'(i);
      end
    end
    // Wrap-around pass: nothing at or above ptr, take the lowest index.
    for (int i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = PW'(i);
      end
    end
  end

endmodule

// File: rtl/swz_dma_sched.sv
// Shares one swizzle_cram_to_dram instance among NUM_REQ CRAM requesters.
// Define SWZ_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module swz_dma_sched
  import swz_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int RAM_AWIDTH   = 9,
  parameter int MEM_AWIDTH   = 9,
  parameter int LEN_WIDTH    = 10,
  parameter int BLOCK_WORDS  = DEF_BLOCK_WORDS,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*MEM_AWIDTH-1:0] req_dst_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  input  logic                          mc_stall,
  output logic                          ram_rd_en,
  output logic [RAM_AWIDTH-1:0]         ram_rd_addr,
  output logic                          sw_data_valid,
  output logic                          sw_data_last,
  output logic [MEM_AWIDTH-1:0]         sw_addr_start
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  sched_state_e state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    err_q, err_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [MEM_AWIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  rd_en;

  logic [MEM_AWIDTH-1:0] addr_arr [NUM_REQ];
  logic [LEN_WIDTH-1:0]  len_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_dst_addr[gi*MEM_AWIDTH +: MEM_AWIDTH];
      assign len_arr[gi]  = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
    end
  endgenerate

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      arb_idx;
  logic               arb_any;

  swz_rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  logic [LEN_WIDTH-1:0] win_len;
  logic                 win_legal;
  logic                 last_word;

  assign win_len   = len_arr[arb_idx];
  assign win_legal = (win_len != '0) && ((win_len % LEN_WIDTH'(BLOCK_WORDS)) == '0);
  assign last_word = (rd_cnt_q == len_q - LEN_WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    err_d    = '0;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    drain_d  = drain_q;
    rd_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          if (win_legal) begin
            gnt_d    = arb_gnt;
            addr_d   = addr_arr[arb_idx];
            len_d    = win_len;
            rd_cnt_d = '0;
            state_d  = LOAD;
          end else begin
            err_d = arb_gnt;
          end
`ifdef SWZ_SCHED_FIXED_PRIO_EN
          ptr_d = '0;
`else
          ptr_d = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + PW'(1);
`endif
        end
      end

      LOAD: begin
        if (!mc_stall) begin
          rd_en = 1'b1;
          if (last_word) begin
            rd_cnt_d = '0;
            drain_d  = '0;
            state_d  = DRAIN;
          end else begin
            rd_cnt_d = rd_cnt_q + LEN_WIDTH'(1);
          end
        end
      end

      // Swizzle buffer empties on its own schedule; backpressure is irrelevant here.
      DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end

      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // CRAM read data appears one cycle after the strobe.
  assign valid_d = rd_en;
  assign last_d  = rd_en && last_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      err_q    <= '0;
      ptr_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      rd_cnt_q <= '0;
      drain_q  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      rd_cnt_q <= rd_cnt_d;
      drain_q  <= drain_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign gnt           = gnt_q;
  assign done          = (state_q == DONE) ? gnt_q : '0;
  assign err           = err_q;
  assign ram_rd_en     = rd_en;
  assign ram_rd_addr   = RAM_AWIDTH'(rd_cnt_q);
  assign sw_data_valid = valid_q;
  assign sw_data_last  = last_q;
  assign sw_addr_start = addr_q;

endmodule
